// File: rtl/clk_sel_ctrl.sv
// Request/settle/dwell controller that drives the glitch-free clock switch select.
// Optional CLK_SEL_CNT_EN adds the saturating real-switch counter output sw_cnt.
module clk_sel_ctrl #(
    parameter bit          DEF_SEL    = 1'b0,
    parameter int unsigned SETTLE_CYC = 16,
    parameter int unsigned DWELL_CYC  = 32,
    parameter int unsigned CNT_W      = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic        req_sel,
    output logic        req_ready,
    output logic        sel,
    output logic        busy,
`ifdef CLK_SEL_CNT_EN
    output logic [15:0] sw_cnt,
`endif
    output logic        done
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        DWELL  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(SETTLE_CYC - 1);
    localparam logic [CNT_W-1:0] DWELL_LD  = (DWELL_CYC == 0) ? '0 : CNT_W'(DWELL_CYC - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             sel_d;
    logic             done_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            sel     <= DEF_SEL;
            done    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sel     <= sel_d;
            done    <= done_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        sel_d     = sel;
        done_d    = 1'b0;
        req_ready = 1'b0;
        busy      = 1'b0;
        case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    if (req_sel == sel) begin
                        done_d = 1'b1;
                    end else begin
                        sel_d   = req_sel;
                        cnt_d   = SETTLE_LD;
                        state_d = SETTLE;
                    end
                end
            end
            SETTLE: begin
                busy = 1'b1;
                if (cnt_q == '0) begin
                    done_d = 1'b1;
                    if (DWELL_CYC == 0) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else begin
                        state_d = DWELL;
                        cnt_d   = DWELL_LD;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            DWELL: begin
                if (cnt_q == '0) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

`ifdef CLK_SEL_CNT_EN
    logic [15:0] sw_cnt_q;

    // A real switch is exactly the edge where the registered select changes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sw_cnt_q <= '0;
        end else if ((sel_d != sel) && (sw_cnt_q != '1)) begin
            sw_cnt_q <= sw_cnt_q + 16'd1;
        end
    end

    assign sw_cnt = sw_cnt_q;
`endif

endmodule

// File: tb/tb_clk_sel_ctrl.sv
// Scoreboard bench for clk_sel_ctrl: random requests against a cycle-number reference model.
module tb_clk_sel_ctrl;

    localparam int S   = 16;
    localparam int D   = 32;
    localparam bit DEF = 1'b0;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic req_valid = 1'b0;
    logic req_sel = 1'b0;
    logic req_ready, sel, busy, done;
`ifdef CLK_SEL_CNT_EN
    logic [15:0] sw_cnt;
`endif

    clk_sel_ctrl #(
        .DEF_SEL   (DEF),
        .SETTLE_CYC(S),
        .DWELL_CYC (D),
        .CNT_W     (8)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req_valid(req_valid),
        .req_sel  (req_sel),
        .req_ready(req_ready),
        .sel      (sel),
        .busy     (busy),
`ifdef CLK_SEL_CNT_EN
        .sw_cnt   (sw_cnt),
`endif
        .done     (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int cyc;
        bit sel;
    } exp_t;

    exp_t q[$];
    int   cyc      = 0;
    int   ready_at = 0;
    int   busy_lo  = 1;
    int   busy_hi  = 0;
    bit   m_sel    = DEF;
    bit   acc_evt  = 1'b0;
    int   n_cmp    = 0;
    int   n_err    = 0;
`ifdef CLK_SEL_CNT_EN
    int   m_cnt    = 0;
`endif

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp, cyc);
        end
    endtask

    function automatic void model_reset();
        q.delete();
        m_sel    = DEF;
        ready_at = cyc;
        busy_lo  = 1;
        busy_hi  = 0;
`ifdef CLK_SEL_CNT_EN
        m_cnt    = 0;
`endif
    endfunction

    // Reference model: the request is taken if the controller was ready during the cycle before the edge.
    always @(posedge clk) begin
        cyc++;
        acc_evt = 1'b0;
        if (rst) begin
            model_reset();
        end else if (req_valid && (cyc - 1 >= ready_at)) begin
            acc_evt = 1'b1;
            if (req_sel == m_sel) begin
                q.push_back('{cyc, m_sel});
            end else begin
                m_sel    = req_sel;
                busy_lo  = cyc;
                busy_hi  = cyc + S - 1;
                ready_at = cyc + S + D;
                q.push_back('{cyc + S, m_sel});
`ifdef CLK_SEL_CNT_EN
                if (m_cnt < 16'hFFFF) m_cnt++;
`endif
            end
        end
    end

    // Monitor: per-cycle level checks plus scoreboard pop on every done pulse.
    always @(negedge clk) begin
        exp_t e;
        chk("req_ready", 32'(req_ready), 32'(rst || (cyc >= ready_at)));
        chk("busy", 32'(busy), 32'(!rst && (cyc >= busy_lo) && (cyc <= busy_hi)));
        chk("sel", 32'(sel), 32'(m_sel));
`ifdef CLK_SEL_CNT_EN
        chk("sw_cnt", 32'(sw_cnt), 32'(m_cnt));
`endif
        if (done) begin
            if (q.size() == 0) begin
                chk("done_unexpected", 32'(done), 32'd0);
            end else begin
                e = q.pop_front();
                chk("done_cycle", 32'(cyc), 32'(e.cyc));
                chk("done_sel", 32'(sel), 32'(e.sel));
            end
        end else if ((q.size() > 0) && (q[0].cyc <= cyc)) begin
            chk("done_missing", 32'(done), 32'd1);
            void'(q.pop_front());
        end
    end

    task automatic do_req(input bit s);
        bit got;
        got = 1'b0;
        req_valid = 1'b1;
        req_sel   = s;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk);
            #1;
            if (acc_evt) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) begin
            n_cmp++;
            n_err++;
            $display("FAIL accept_timeout: got no accept expected accept within 200 cycles");
        end
        #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 200 && cyc < ready_at + 1; i++) @(posedge clk);
        #2;
    endtask

    // Asserts reset between edges and checks the outputs before any clock.
    task automatic async_reset(input int hold);
        @(posedge clk);
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        chk("async_rst_sel", 32'(sel), 32'(DEF));
        chk("async_rst_busy", 32'(busy), 32'd0);
        chk("async_rst_done", 32'(done), 32'd0);
        chk("async_rst_ready", 32'(req_ready), 32'd1);
`ifdef CLK_SEL_CNT_EN
        chk("async_rst_sw_cnt", 32'(sw_cnt), 32'd0);
`endif
        repeat (hold) @(posedge clk);
        #2;
        rst = 1'b0;
    endtask

    initial begin
        repeat (5) @(posedge clk);
        #2;
        rst = 1'b0;

        // Switch 0->1, then a request for 0 held from E+5 through the settle/dwell window.
        do_req(1'b1);
        repeat (4) @(posedge clk);
        #2;
        do_req(1'b0);

        // Two back-to-back no-ops.
        wait_idle();
        req_valid = 1'b1;
        req_sel   = m_sel;
        repeat (2) @(posedge clk);
        #2;
        req_valid = 1'b0;
        wait_idle();

        // Reset at E+8 during settle, then a request on the first cycle after release.
        do_req(~m_sel);
        repeat (7) @(posedge clk);
        async_reset(2);
        do_req(1'b1);
        wait_idle();

`ifdef CLK_SEL_CNT_EN
        force dut.sw_cnt_q = 16'hFFFE;
        #1;
        release dut.sw_cnt_q;
        m_cnt = 16'hFFFE;
`endif

        for (int i = 0; i < 3000; i++) begin
            if (!(req_valid && !acc_evt)) begin
                req_valid = ($urandom_range(0, 3) == 0);
                req_sel   = 1'($urandom_range(0, 1));
            end
            @(posedge clk);
            #2;
        end
        req_valid = 1'b0;
        repeat (100) @(posedge clk);
        #2;
        chk("scoreboard_drained", 32'(q.size()), 32'd0);

        async_reset(2);
        repeat (3) @(posedge clk);
        #2;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
